instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch stage: walks a 16-entry instruction memory and hands one
// registered instruction per cycle to the execute stage. It stops permanently on the 8'hFF HALT opcode.
module instr_fetch_unit (
    input  logic       main_clk,
    input  logic       rst,
    input  logic       run,
    output logic [3:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect,
    input  logic [3:0] redirect_addr,
    output logic [3:0] pc,
    output logic       halted,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    localparam logic [7:0] HaltOp     = 8'hFF;
    localparam logic [7:0] RetiredMax = 8'hFF;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic       instr_valid_q, instr_valid_d;
    logic       halted_q, halted_d;
    logic [7:0] retired_q, retired_d;

    logic consume;
    logic fetch;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        retired_d     = retired_q;

        consume = (state_q == StRun) && instr_valid_q && instr_ready;
        fetch   = (state_q == StRun) && run && !redirect && (!instr_valid_q || instr_ready);

        if (consume && (retired_q != RetiredMax)) begin
            retired_d = retired_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    pc_d = redirect_addr;
                end
                if (run) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Redirect flushes any held instruction; a same-edge consume has already retired it.
                if (redirect) begin
                    pc_d          = redirect_addr;
                    instr_valid_d = 1'b0;
                end else if (fetch) begin
                    if (mem_data == HaltOp) begin
                        instr_valid_d = 1'b0;
                        halted_d      = 1'b1;
                        state_d       = StHalted;
                    end else begin
                        instr_d       = mem_data;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 4'd1;
                    end
                end else if (consume) begin
                    instr_valid_d = 1'b0;
                end
            end
            StHalted: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= 4'd0;
            instr_q       <= 8'h00;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            retired_q     <= retired_d;
        end
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a cycle-level behavioural model.
module tb_instr_fetch_unit;

    logic       main_clk;
    logic       rst;
    logic       run;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect;
    logic [3:0] redirect_addr;
    logic [3:0] pc;
    logic       halted;
    logic [7:0] retired;

    logic [7:0] mem [16];
    assign mem_data = mem[mem_addr];

    instr_fetch_unit dut (
        .main_clk      (main_clk),
        .rst           (rst),
        .run           (run),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .pc            (pc),
        .halted        (halted),
        .retired       (retired)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
    int         m_mode;
    logic [3:0] m_pc;
    logic [7:0] m_instr;
    logic [7:0] m_retired;
    bit         m_valid;
    bit         m_halted;

    task automatic model_reset();
        m_mode = 0; m_pc = 4'd0; m_instr = 8'h00; m_retired = 8'd0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // Applies the fetch rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit took;
        if (m_mode == 2) return;
        if (m_mode == 0) begin
            if (redirect) m_pc = redirect_addr;
            if (run) m_mode = 1;
            return;
        end
        took = m_valid && instr_ready;
        if (took && m_retired < 8'd255) m_retired = m_retired + 8'd1;
        if (redirect) begin
            m_pc = redirect_addr;
            m_valid = 1'b0;
        end else if (run && (!m_valid || instr_ready)) begin
            if (mem[m_pc] == 8'hFF) begin
                m_valid = 1'b0; m_halted = 1'b1; m_mode = 2;
            end else begin
                m_instr = mem[m_pc];
                m_valid = 1'b1;
                m_pc = 4'((int'(m_pc) + 1) % 16);
            end
        end else if (took) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " instr"}, instr, m_instr);
        check({tag, " valid"}, 8'(instr_valid), 8'(m_valid));
        check({tag, " pc"}, 8'(pc), 8'(m_pc));
        check({tag, " mem_addr"}, 8'(mem_addr), 8'(m_pc));
        check({tag, " halted"}, 8'(halted), 8'(m_halted));
        check({tag, " retired"}, retired, m_retired);
    endtask

    // Called away from the clock edge; the pulse never straddles a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic set_in(input bit r, input bit rdy, input bit rd, input logic [3:0] ra);
        run = r; instr_ready = rdy; redirect = rd; redirect_addr = ra;
    endtask

    task automatic load_prog();
        mem[0] = 8'h91; mem[1] = 8'h61; mem[2] = 8'h93; mem[3] = 8'hFF;
        for (int i = 4; i < 16; i++) mem[i] = 8'(8'h20 + i);
    endtask

    task automatic load_no_halt();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 254));
    endtask

    typedef struct {
        bit         pre_rst;
        bit         run;
        bit         rdy;
        bit         rdr;
        logic [3:0] ra;
        logic [7:0] e_instr;
        bit         e_valid;
        logic [3:0] e_pc;
        bit         e_halted;
        logic [7:0] e_retired;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit pre, input bit r, input bit rdy, input bit rd,
                           input logic [3:0] ra, input logic [7:0] ei, input bit ev,
                           input logic [3:0] ep, input bit eh, input logic [7:0] er);
        vec_t v;
        v.pre_rst = pre; v.run = r; v.rdy = rdy; v.rdr = rd; v.ra = ra;
        v.e_instr = ei; v.e_valid = ev; v.e_pc = ep; v.e_halted = eh; v.e_retired = er;
        vecs.push_back(v);
    endtask

    initial begin
        int halt_cycles;
        set_in(1'b0, 1'b0, 1'b0, 4'd0);
        load_prog();
        rst = 1'b1;
        #1;
        check("reset instr", instr, 8'h00);
        check("reset valid", 8'(instr_valid), 8'd0);
        check("reset pc", 8'(pc), 8'd0);
        check("reset halted", 8'(halted), 8'd0);
        check("reset retired", retired, 8'd0);
        tick();
        rst = 1'b0;
        model_reset();

        // Straight-line program with halt, then back-pressure / run-drop sequence.
        add_vec(1, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        add_vec(0, 1, 1, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 1, 1, 0, 0, 8'h61, 1, 2, 0, 1);
        add_vec(0, 1, 1, 0, 0, 8'h93, 1, 3, 0, 2);
        add_vec(0, 1, 1, 0, 0, 8'h93, 0, 3, 1, 3);
        add_vec(0, 1, 1, 1, 5, 8'h93, 0, 3, 1, 3);
        add_vec(1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 1, 0, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 1, 0, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 1, 0, 0, 0, 8'h91, 1, 1, 0, 0);
        add_vec(0, 1, 1, 0, 0, 8'h61, 1, 2, 0, 1);
        add_vec(0, 0, 1, 0, 0, 8'h61, 0, 2, 0, 2);
        add_vec(0, 0, 1, 0, 0, 8'h61, 0, 2, 0, 2);
        add_vec(0, 1, 0, 0, 0, 8'h93, 1, 3, 0, 2);
        add_vec(0, 1, 0, 0, 0, 8'h93, 1, 3, 0, 2);

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) do_reset();
            set_in(vecs[i].run, vecs[i].rdy, vecs[i].rdr, vecs[i].ra);
            tick();
            check($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
            check($sformatf("vec%0d valid", i), 8'(instr_valid), 8'(vecs[i].e_valid));
            check($sformatf("vec%0d pc", i), 8'(pc), 8'(vecs[i].e_pc));
            check($sformatf("vec%0d halted", i), 8'(halted), 8'(vecs[i].e_halted));
            check($sformatf("vec%0d retired", i), retired, vecs[i].e_retired);
        end

        // Redirect with a same-edge handshake: retire, flush, refetch from target.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 4'd0);
        repeat (3) tick();
        check("redir pre instr", instr, 8'h61);
        set_in(1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        check("redir retired", retired, 8'd2);
        check("redir valid", 8'(instr_valid), 8'd0);
        check("redir pc", 8'(pc), 8'd2);
        set_in(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check("redir refetch", instr, 8'h93);
        check("redir refetch valid", 8'(instr_valid), 8'd1);

        // Redirect in idle, then pc wrap from 15.
        mem[15] = 8'h10;
        do_reset();
        set_in(1'b0, 1'b1, 1'b1, 4'd15);
        tick();
        check("idle redir pc", 8'(pc), 8'd15);
        set_in(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check("idle no fetch", 8'(instr_valid), 8'd0);
        tick();
        check("wrap instr", instr, 8'h10);
        check("wrap pc", 8'(pc), 8'd0);

        // Retired counter saturation.
        load_no_halt();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 302; k++) begin
            tick();
            if (k == 256) check("sat pre", retired, 8'd254);
        end
        check("sat retired", retired, 8'd255);

        // Asynchronous reset between edges with an instruction pending.
        do_reset();
        repeat (6) tick();
        check("async pre pc", 8'(pc), 8'd5);
        check("async pre valid", 8'(instr_valid), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async pc", 8'(pc), 8'd0);
        check("async valid", 8'(instr_valid), 8'd0);
        check("async retired", retired, 8'd0);
        check("async instr", instr, 8'h00);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset out of HALTED restarts from pc 0.
        load_prog();
        do_reset();
        repeat (6) tick();
        check("halt reached", 8'(halted), 8'd1);
        do_reset();
        check("halt reset halted", 8'(halted), 8'd0);
        check("halt reset retired", retired, 8'd0);
        repeat (2) tick();
        check("restart instr", instr, 8'h91);
        check("restart pc", 8'(pc), 8'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        do_reset();
        halt_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_mode == 2) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 199) == 0) begin
                halt_cycles = 0;
                for (int i = 0; i < 16; i++)
                    mem[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                do_reset();
                compare_model($sformatf("rnd%0d rst", c));
            end
            set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
            model_edge();
            tick();
            compare_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
